// File: rtl/switch_pkg.sv
// Shared frame-link definitions: frame geometry, field positions,
// delimiter, broadcast address and receiver FSM encoding.
package switch_pkg;

  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int SFD_WIDTH  = 4;

  localparam logic [SFD_WIDTH-1:0] SFD = 4'b0101;

  localparam int DST_MSB     = DEPTH - SFD_WIDTH - 1;
  localparam int DST_LSB     = DST_MSB - ADDR_WIDTH + 1;
  localparam int SRC_MSB     = DST_LSB - 1;
  localparam int SRC_LSB     = SRC_MSB - ADDR_WIDTH + 1;
  localparam int PAYLOAD_MSB = SRC_LSB - 1;

  localparam logic [ADDR_WIDTH-1:0] BROADCAST_ADDR = '1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_CHECK
  } rx_state_t;

  function automatic logic sfd_ok(
    input logic [DEPTH-1:0] f
  );
    return f[DEPTH-1 -: SFD_WIDTH] == SFD;
  endfunction

endpackage

// File: rtl/switch_rx_port_fifo.sv
// Frame FIFO: push/pop with count; room reports whether a push lands.
// Ports: clk, rst, push, din, pop -> head, empty, room, count.
module frame_fifo #(
  parameter  int WIDTH   = 16,
  parameter  int ENTRIES = 4,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             room,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(ENTRIES);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO lacks.
  assign room    = !full || do_pop;
  assign do_push = push && room;
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/switch_rx_port.sv
// Switch ingress receiver: deserializes frames, checks SFD, queues them.
// Ports: clk, rst, rx_bit in; out_* handshake, drop pulses, fifo_count.
module switch_rx_port
  import switch_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_bit,
  output logic [DEPTH-1:0]      out_frame,
  output logic [ADDR_WIDTH-1:0] out_dst,
  output logic [ADDR_WIDTH-1:0] out_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  drop_sfd,
  output logic                  drop_full,
  output logic [CW-1:0]         fifo_count
);

  localparam int BW = $clog2(DEPTH);

  rx_state_t        state;
  logic             rx_bit_d1;
  logic [DEPTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             start;
  logic             sfd_good;
  logic             push;
  logic             pop;
  logic             room;
  logic             empty;

  assign start    = rx_bit_d1 && !rx_bit;
  assign sfd_good = sfd_ok(shreg);
  assign push     = (state == RX_CHECK) && sfd_good;
  assign pop      = out_valid && out_ready;

  frame_fifo #(
    .WIDTH   (DEPTH),
    .ENTRIES (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .head  (out_frame),
    .empty (empty),
    .room  (room),
    .count (fifo_count)
  );

  assign out_valid = !empty;
  assign out_dst   = out_frame[DST_MSB:DST_LSB];
  assign out_src   = out_frame[SRC_MSB:SRC_LSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      rx_bit_d1 <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      drop_sfd  <= 1'b0;
      drop_full <= 1'b0;
    end else begin
      rx_bit_d1 <= rx_bit;
      drop_sfd  <= 1'b0;
      drop_full <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (start) begin
            shreg   <= {shreg[DEPTH-2:0], rx_bit};
            bit_cnt <= BW'(DEPTH - 1);
            state   <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          shreg   <= {shreg[DEPTH-2:0], rx_bit};
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == BW'(1))
            state <= RX_CHECK;
        end
        RX_CHECK: begin
          // rx_bit carries the guard bit here and is not looked at.
          drop_sfd  <= !sfd_good;
          drop_full <= sfd_good && !room;
          state     <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_rx_port.sv
// Scoreboard bench for switch_rx_port: directed cases then random traffic.
// Model tracks queued frames and expected drops per clock edge.
module tb_switch_rx_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_bit = 1'b1;
  logic [15:0] out_frame;
  logic [3:0]  out_dst;
  logic [3:0]  out_src;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        drop_sfd;
  logic        drop_full;
  logic [2:0]  fifo_count;

  switch_rx_port #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_bit     (rx_bit),
    .out_frame  (out_frame),
    .out_dst    (out_dst),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_sfd   (drop_sfd),
    .drop_full  (drop_full),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          chk_edge;
    logic [15:0] frame;
  } ev_t;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  ev_t         ev_q[$];
  logic [15:0] exp_q[$];
  int          model_cnt = 0;
  bit          exp_sfd = 0;
  bit          exp_full = 0;
  bit          rand_ready_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Model: at each falling edge compare against the state after the last
  // rising edge, then work out what the next rising edge does.
  always @(negedge clk) begin
    logic [15:0] f;
    bit          mpop;
    bit          mpush;
    if (rst) begin
      exp_q.delete();
      ev_q.delete();
      model_cnt = 0;
      exp_sfd   = 0;
      exp_full  = 0;
    end else begin
      chk("fifo_count", 32'(fifo_count), 32'(model_cnt));
      chk("out_valid", 32'(out_valid), 32'(model_cnt > 0));
      chk("drop_sfd", 32'(drop_sfd), 32'(exp_sfd));
      chk("drop_full", 32'(drop_full), 32'(exp_full));
      mpop  = 0;
      mpush = 0;
      if (model_cnt > 0 && out_ready) begin
        mpop = 1;
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 32'(1), 32'(0));
        end else begin
          f = exp_q.pop_front();
          chk("out_frame", 32'(out_frame), 32'(f));
          chk("out_dst", 32'(out_dst), 32'(f[11:8]));
          chk("out_src", 32'(out_src), 32'(f[7:4]));
        end
      end
      exp_sfd  = 0;
      exp_full = 0;
      if (ev_q.size() > 0 && ev_q[0].chk_edge == cyc + 1) begin
        f = ev_q[0].frame;
        void'(ev_q.pop_front());
        if (f[15:12] != 4'b0101)
          exp_sfd = 1;
        else if (model_cnt < 4 || mpop) begin
          mpush = 1;
          exp_q.push_back(f);
        end else
          exp_full = 1;
      end
      model_cnt = model_cnt + int'(mpush) - int'(mpop);
    end
  end

  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [15:0] f, input bit ready_pulse);
    ev_t e;
    @(posedge clk); #1;
    e.chk_edge = cyc + 17;
    e.frame    = f;
    ev_q.push_back(e);
    rx_bit = f[15];
    for (int i = 14; i >= 0; i--) begin
      @(posedge clk); #1;
      rx_bit = f[i];
    end
    @(posedge clk); #1;
    rx_bit = 1'b0;
    if (ready_pulse) out_ready = 1'b1;
    @(posedge clk); #1;
    rx_bit = 1'b1;
    if (ready_pulse) out_ready = 1'b0;
  endtask

  task automatic send_partial(input logic [15:0] f, input int nb);
    for (int i = 15; i > 15 - nb; i--) begin
      @(posedge clk); #1;
      rx_bit = f[i];
    end
    @(posedge clk); #1;
    rx_bit = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_bit = 1'b1;
    end
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_fifo_count", 32'(fifo_count), 32'(0));
    chk("rst_drop_sfd", 32'(drop_sfd), 32'(0));
    chk("rst_drop_full", 32'(drop_full), 32'(0));
    chk("rst_out_frame", 32'(out_frame), 32'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_frame(input bit good);
    logic [15:0] f;
    logic [3:0]  bad [7];
    bad = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7};
    f = 16'($urandom);
    if (good)
      f[15:12] = 4'h5;
    else
      f[15:12] = bad[$urandom_range(0, 6)];
    return f;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    idle(3);

    // Single frame, then bad delimiter followed back to back by a good one.
    send(16'h5A3C, 0);
    idle(3);
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;
    send(16'h6A3C, 0);
    send(16'h5B21, 0);
    idle(3);
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;

    // Overflow: five frames into a four-deep FIFO, then drain.
    for (int i = 0; i < 5; i++)
      send({4'h5, 4'(i), 8'(8'hC0 + i)}, 0);
    idle(3);
    out_ready = 1'b1;
    idle(6);
    out_ready = 1'b0;

    // Full FIFO with a pop on the very cycle the fifth frame lands.
    for (int i = 0; i < 4; i++)
      send({4'h5, 4'(i + 8), 8'(8'h30 + i)}, 0);
    send(16'h5E77, 1);
    idle(3);
    out_ready = 1'b1;
    idle(6);
    out_ready = 1'b0;

    // Reset in the middle of a frame, with a frame already queued.
    send(16'h5D11, 0);
    send_partial(16'h5F00, 8);
    do_reset();
    idle(2);
    send(16'h5123, 0);
    idle(2);
    out_ready = 1'b1;
    idle(2);

    // Continuous drain across pointer wrap.
    for (int i = 0; i < 8; i++)
      send({4'h5, 4'(15 - i), 8'(8'h90 + i)}, 0);
    idle(3);
    out_ready = 1'b0;

    // Random traffic with random back-pressure.
    rand_ready_en = 1;
    for (int i = 0; i < 40; i++) begin
      send(rand_frame($urandom_range(0, 9) < 8), 0);
      idle($urandom_range(0, 3));
    end
    rand_ready_en = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(10);

    chk("leftover_frames", 32'(exp_q.size()), 32'(0));
    chk("leftover_events", 32'(ev_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
